// File: rtl/snn_pkg.sv
// Shared types and sizing helpers for the spiking-network readout blocks.
package snn_pkg;

   // Decoder phases: idle, collecting spikes, holding a result for the consumer.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WINDOW = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int N_NEURONS_DEF = 4;
   localparam int T_WINDOW_DEF  = 250;

   // A first-time register holding this value means "has not spiked yet".
   localparam int T_SENTINEL = T_WINDOW_DEF;

   // Smallest time width that can hold the sentinel value T_WINDOW.
   function automatic int tw_for(input int t_window);
      return $clog2(t_window + 1);
   endfunction

   // Class index width; never below one bit.
   function automatic int cw_for(input int n_neurons);
      return (n_neurons < 2) ? 1 : $clog2(n_neurons);
   endfunction

endpackage

// File: rtl/spike_argmin.sv
// Combinational earliest-spike finder: minimum time among neurons that have
// spiked, with the lowest index winning a tie. Reports index 0 / time 0 when
// no neuron has spiked.
module spike_argmin #(
   parameter int N  = 4,
   parameter int TW = 8,
   parameter int CW = 2
) (
   input  logic [N-1:0][TW-1:0] times,
   input  logic [N-1:0]         seen,
   output logic [CW-1:0]        min_idx,
   output logic [TW-1:0]        min_time,
   output logic                 any_seen
);

   // Scan in index order; a strict less-than keeps the earlier index on ties.
   always_comb begin
      min_idx  = '0;
      min_time = '0;
      any_seen = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (seen[i] && (!any_seen || (times[i] < min_time))) begin
            min_idx  = CW'(i);
            min_time = times[i];
            any_seen = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spike_time_decoder.sv
// Time-to-first-spike readout: watches the output neurons for one window of
// enabled cycles, records each neuron's first spike time, and presents the
// earliest neuron (the winner) to the consumer.
//
// Result handshake: out_valid rises on the first REPORT cycle and out_class,
// out_time, out_none are stable while it is high. A transfer happens on a
// rising clk edge where out_valid && out_ready; out_valid drops the cycle
// after, data fields keep their last value, and out_valid never depends on
// out_ready.
module spike_time_decoder
   import snn_pkg::*;
#(
   parameter int N_NEURONS = N_NEURONS_DEF,
   parameter int T_WINDOW  = T_WINDOW_DEF,
   parameter int TW        = tw_for(T_WINDOW),
   parameter int CW        = cw_for(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 start,
   input  logic [N_NEURONS-1:0] in_spike,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_class,
   output logic [TW-1:0]        out_time,
   output logic                 out_none,
   output state_t               dbg_state
);

   localparam logic [TW-1:0] T_LAST = TW'(T_WINDOW - 1);
   localparam logic [TW-1:0] T_SENT = TW'(T_WINDOW);

   state_t                       state_q, state_d;
   logic [TW-1:0]                t_q, t_d;
   logic [N_NEURONS-1:0]         seen_q, seen_d;
   logic [N_NEURONS-1:0][TW-1:0] ft_q, ft_d;
   logic                         load_out;
   logic                         handshake;
   logic [CW-1:0]                am_idx;
   logic [TW-1:0]                am_time;
   logic                         am_any;

   assign handshake = (state_q == REPORT) && out_valid && out_ready;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   // The winner is taken from the next-state captures so that spikes on the
   // final window step take part in the result registered on REPORT entry.
   spike_argmin #(
      .N  (N_NEURONS),
      .TW (TW),
      .CW (CW)
   ) u_argmin (
      .times    (ft_d),
      .seen     (seen_d),
      .min_idx  (am_idx),
      .min_time (am_time),
      .any_seen (am_any)
   );

   // Next-state logic: window open, per-step first-spike capture, report exit.
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      seen_d   = seen_q;
      ft_d     = ft_q;
      load_out = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WINDOW;
               t_d     = '0;
               seen_d  = '0;
               ft_d    = {N_NEURONS{T_SENT}};
            end
         end
         WINDOW: begin
            if (en) begin
               for (int i = 0; i < N_NEURONS; i++) begin
                  if (in_spike[i] && !seen_q[i]) begin
                     ft_d[i]   = t_q;
                     seen_d[i] = 1'b1;
                  end
               end
               if (t_q == T_LAST) begin
                  state_d  = REPORT;
                  load_out = 1'b1;
               end else begin
                  t_d = t_q + TW'(1);
               end
            end
         end
         REPORT: begin
            if (handshake) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, step counter and capture registers; reset drops any captures.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         seen_q  <= '0;
         ft_q    <= {N_NEURONS{T_SENT}};
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         seen_q  <= seen_d;
         ft_q    <= ft_d;
      end
   end

   // Result registers: loaded on REPORT entry, valid cleared after transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_class <= '0;
         out_time  <= '0;
         out_none  <= 1'b0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_class <= am_idx;
         out_time  <= am_time;
         out_none  <= ~am_any;
      end else if (handshake) begin
         out_valid <= 1'b0;
      end
   end

endmodule
